// File: rtl/pipe_control_if.sv
// Handshake and strobe bundle between the pipeline controller (master)
// and the datapath / memory side (slave).
interface pipe_control_if #(
  parameter int CNT_W = 32
);
  logic             pipe_control_stall_in;
  logic             pipe_control_imem_req_out;
  logic             pipe_control_imem_ready_in;
  logic [6:0]       pipe_control_ins_data_in;
  logic             pipe_control_ir_set_val_out;
  logic             pipe_control_alu_en_out;
  logic             pipe_control_dmem_req_out;
  logic             pipe_control_dmem_we_out;
  logic             pipe_control_dmem_ready_in;
  logic             pipe_control_branch_taken_in;
  logic             pipe_control_reg_write_out;
  logic             pipe_control_pc_set_val_out;
  logic [1:0]       pipe_control_pc_mux_sel_out;
  logic             pipe_control_trap_out;
  logic [1:0]       pipe_control_trap_cause_out;
  logic [CNT_W-1:0] pipe_control_retired_count_out;
  logic [2:0]       pipe_control_state_out;

  modport master (
    input  pipe_control_stall_in, pipe_control_imem_ready_in, pipe_control_ins_data_in,
           pipe_control_dmem_ready_in, pipe_control_branch_taken_in,
    output pipe_control_imem_req_out, pipe_control_ir_set_val_out, pipe_control_alu_en_out,
           pipe_control_dmem_req_out, pipe_control_dmem_we_out, pipe_control_reg_write_out,
           pipe_control_pc_set_val_out, pipe_control_pc_mux_sel_out, pipe_control_trap_out,
           pipe_control_trap_cause_out, pipe_control_retired_count_out, pipe_control_state_out
  );

  modport slave (
    output pipe_control_stall_in, pipe_control_imem_ready_in, pipe_control_ins_data_in,
           pipe_control_dmem_ready_in, pipe_control_branch_taken_in,
    input  pipe_control_imem_req_out, pipe_control_ir_set_val_out, pipe_control_alu_en_out,
           pipe_control_dmem_req_out, pipe_control_dmem_we_out, pipe_control_reg_write_out,
           pipe_control_pc_set_val_out, pipe_control_pc_mux_sel_out, pipe_control_trap_out,
           pipe_control_trap_cause_out, pipe_control_retired_count_out, pipe_control_state_out
  );
endinterface

// File: rtl/pipe_control.sv
// Multi-cycle pipeline sequencer: fetch, decode, execute, memory, writeback
// with illegal-opcode and bus-timeout traps.
//
//  state | meaning
//  IF    | fetch request, wait for imem ready (timeout -> TRAP)
//  ID    | legality check of latched opcode
//  EX    | one-cycle ALU enable
//  MEM   | data access for LOAD/STORE (timeout -> TRAP)
//  WB    | register write / PC update, retire
//  TRAP  | vector PC to trap handler
module pipe_control #(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic           pipe_control_clock_in,
  input logic           pipe_control_reset_in,
  pipe_control_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b011,
    S_MEM  = 3'b010,
    S_WB   = 3'b110,
    S_TRAP = 3'b111
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

  state_t             state_q, state_d;
  logic [6:0]         opcode_q, opcode_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic       imem_req, ir_set, alu_en, dmem_req, dmem_we;
  logic       reg_write, pc_set, trap;
  logic [1:0] pc_sel;
  logic       stall, legal, is_mem, is_store, timeout_hit;

  assign stall       = bus.pipe_control_stall_in;
  assign is_store    = (opcode_q == OP_STORE);
  assign is_mem      = (opcode_q == OP_LOAD) || is_store;
  assign legal       = (opcode_q inside {OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_LUI,
                                         OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR});
  // A ready on the limit cycle is checked first, so it always wins.
  assign timeout_hit = (MEM_WAIT_MAX > 0) && (wait_q == WAIT_LIM);

  // State and bookkeeping registers; reset overrides stall and any access.
  always_ff @(posedge pipe_control_clock_in) begin
    if (pipe_control_reset_in) begin
      state_q   <= S_IF;
      opcode_q  <= '0;
      wait_q    <= '0;
      cause_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and strobe decode; a stall freezes all register updates.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    wait_d    = wait_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    imem_req  = 1'b0;
    ir_set    = 1'b0;
    alu_en    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    pc_set    = 1'b0;
    pc_sel    = 2'b00;
    trap      = 1'b0;
    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (!stall) begin
          if (bus.pipe_control_imem_ready_in) begin
            ir_set   = 1'b1;
            opcode_d = bus.pipe_control_ins_data_in;
            state_d  = S_ID;
          end else if (timeout_hit) begin
            cause_d = 2'b10;
            state_d = S_TRAP;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      S_ID: begin
        if (!stall) begin
          if (legal) begin
            state_d = S_EX;
          end else begin
            cause_d = 2'b01;
            state_d = S_TRAP;
          end
        end
      end
      S_EX: begin
        alu_en = !stall;
        if (!stall) begin
          if (is_mem) begin
            wait_d  = '0;
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (!stall) begin
          if (bus.pipe_control_dmem_ready_in) begin
            state_d = S_WB;
          end else if (timeout_hit) begin
            cause_d = 2'b10;
            state_d = S_TRAP;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      S_WB: begin
        pc_set    = !stall;
        reg_write = !stall && !is_store && (opcode_q != OP_BRANCH);
        if ((opcode_q == OP_JAL) || (opcode_q == OP_JALR)) begin
          pc_sel = 2'b10;
        end else if ((opcode_q == OP_BRANCH) && bus.pipe_control_branch_taken_in) begin
          pc_sel = 2'b01;
        end
        if (!stall) begin
          retired_d = retired_q + 1'b1;
          wait_d    = '0;
          state_d   = S_IF;
        end
      end
      S_TRAP: begin
        trap   = 1'b1;
        pc_set = !stall;
        pc_sel = 2'b11;
        if (!stall) begin
          wait_d  = '0;
          state_d = S_IF;
        end
      end
      default: state_d = S_IF;
    endcase
  end

  // Every output reads zero while reset is held.
  logic run;
  assign run = !pipe_control_reset_in;

  assign bus.pipe_control_imem_req_out      = run & imem_req;
  assign bus.pipe_control_ir_set_val_out    = run & ir_set;
  assign bus.pipe_control_alu_en_out        = run & alu_en;
  assign bus.pipe_control_dmem_req_out      = run & dmem_req;
  assign bus.pipe_control_dmem_we_out       = run & dmem_we;
  assign bus.pipe_control_reg_write_out     = run & reg_write;
  assign bus.pipe_control_pc_set_val_out    = run & pc_set;
  assign bus.pipe_control_pc_mux_sel_out    = {2{run}} & pc_sel;
  assign bus.pipe_control_trap_out          = run & trap;
  assign bus.pipe_control_trap_cause_out    = {2{run}} & cause_q;
  assign bus.pipe_control_retired_count_out = {CNT_W{run}} & retired_q;
  assign bus.pipe_control_state_out         = {3{run}} & state_q;

endmodule
